// File: rtl/rdn_in_buffer.sv
// rdn_in_buffer: double-buffered window stage between the HEU and the RDN input.
// A whole equalized window is captured in one cycle into a free bank and then
// streamed out as LANES-pixel beats under valid/ready flow control.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   heu_out_ready   HEU presents a complete window on heu_data
//   heu_data        window, pixel i at [i*PIX_W +: PIX_W]
//   rdn_in_ready    a bank is free; window taken this cycle if heu_out_ready=1
//   out_valid       out_data holds a valid beat
//   out_data        beat, lane j at [j*PIX_W +: PIX_W]
//   out_last        current beat is the final beat of the window
//   out_ready       downstream consumes the beat when out_valid=1
//   buf_count       number of full banks (0..2)
module rdn_in_buffer #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned WIN_PIX = 400,
  parameter int unsigned LANES   = 5    // WIN_PIX must be a multiple of LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     heu_out_ready,
  input  logic [WIN_PIX*PIX_W-1:0] heu_data,
  output logic                     rdn_in_ready,
  output logic                     out_valid,
  output logic [LANES*PIX_W-1:0]   out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [1:0]               buf_count
);

  localparam int unsigned WIN_W   = WIN_PIX * PIX_W;
  localparam int unsigned BEAT_W  = LANES * PIX_W;
  localparam int unsigned BEATS   = WIN_PIX / LANES;
  localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] S_EMPTY  = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [WIN_W-1:0]   r_bank0;
  logic [WIN_W-1:0]   r_bank1;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [BEAT_CW-1:0] r_beat;
  logic [0:0]         r_state;

  logic [0:0]         w_state_nxt;
  logic [BEAT_CW-1:0] w_beat_nxt;
  logic               w_rd_ptr_nxt;
  logic [1:0]         w_count_nxt;
  logic               w_load;
  logic               w_accept;
  logic               w_is_last;
  logic               w_final;
  logic [WIN_W-1:0]   w_bank_rd;

  // Handshake decode, all from registered state so ready never depends on out_ready
  assign rdn_in_ready = (r_count != 2'd2);
  assign w_load       = heu_out_ready & rdn_in_ready;
  assign w_accept     = (r_state == S_STREAM) & out_ready;
  assign w_is_last    = (r_beat == BEAT_CW'(BEATS - 1));
  assign w_final      = w_accept & w_is_last;
  assign w_count_nxt  = r_count + 2'(w_load) - 2'(w_final);

  // Output beat mux
  assign w_bank_rd = r_rd_ptr ? r_bank1 : r_bank0;
  assign out_data  = w_bank_rd[32'(r_beat) * BEAT_W +: BEAT_W];
  assign out_valid = (r_state == S_STREAM);
  assign out_last  = out_valid & w_is_last;
  assign buf_count = r_count;

  // Read FSM next-state; the final beat hands straight over to the other bank
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    w_rd_ptr_nxt = r_rd_ptr;
    case (r_state)
      S_EMPTY: begin
        if (r_count != 2'd0) begin
          w_state_nxt = S_STREAM;
          w_beat_nxt  = '0;
        end
      end
      S_STREAM: begin
        if (w_final) begin
          w_beat_nxt   = '0;
          w_rd_ptr_nxt = ~r_rd_ptr;
          if (w_count_nxt == 2'd0) begin
            w_state_nxt = S_EMPTY;
          end
        end else if (w_accept) begin
          w_beat_nxt = r_beat + BEAT_CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_beat   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_load) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
    end
  end

  // Bank storage; contents are meaningless after reset, so no reset here
  always_ff @(posedge clk) begin
    if (w_load) begin
      if (r_wr_ptr) begin
        r_bank1 <= heu_data;
      end else begin
        r_bank0 <= heu_data;
      end
    end
  end

endmodule

// File: tb/tb_rdn_in_buffer.sv
module tb_rdn_in_buffer;

  localparam int PIX_W   = 8;
  localparam int WIN_PIX = 400;
  localparam int LANES   = 5;
  localparam int BEATS   = WIN_PIX / LANES;
  localparam int WIN_W   = WIN_PIX * PIX_W;
  localparam int BEAT_W  = LANES * PIX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              heu_out_ready;
  logic [WIN_W-1:0]  heu_data;
  logic              rdn_in_ready;
  logic              out_valid;
  logic [BEAT_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic [1:0]        buf_count;

  rdn_in_buffer #(.PIX_W(PIX_W), .WIN_PIX(WIN_PIX), .LANES(LANES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .heu_out_ready(heu_out_ready),
    .heu_data     (heu_data),
    .rdn_in_ready (rdn_in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .buf_count    (buf_count)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of whole windows plus the beat position of the head
  logic [WIN_W-1:0] q[$];
  int  m_beat = 0;
  bit  m_valid = 1'b0;
  int  checks = 0;
  int  failures = 0;
  int  beats_acc = 0;
  int  windows_done = 0;
  int  max_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] gen(input int mode);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < WIN_PIX; i++) begin
      case (mode)
        0:       w[i*PIX_W +: PIX_W] = 8'(i % 256);
        1:       w[i*PIX_W +: PIX_W] = 8'h11;
        2:       w[i*PIX_W +: PIX_W] = 8'h22;
        3:       w[i*PIX_W +: PIX_W] = 8'(255 - (i % 256));
        default: w[i*PIX_W +: PIX_W] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model at posedge
  task automatic cycle(input bit hv, input logic [WIN_W-1:0] hd, input bit ordy, input bit rst);
    logic [WIN_W-1:0]  fw;
    logic [BEAT_W-1:0] e;
    bit load, acc, fin;
    int old_size;
    @(negedge clk);
    heu_out_ready = hv;
    heu_data      = hd;
    out_ready     = ordy;
    rst_n         = !rst;
    #1;
    if (!rst) begin
      chk("rdn_in_ready", 64'(rdn_in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("buf_count", 64'(buf_count), 64'(q.size()));
      chk("out_last", 64'(out_last), 64'(m_valid && m_beat == BEATS - 1));
      if (m_valid) begin
        fw = q[0];
        for (int j = 0; j < LANES; j++)
          e[j*PIX_W +: PIX_W] = fw[(m_beat*LANES + j)*PIX_W +: PIX_W];
        chk("out_data", 64'(out_data), 64'(e));
      end
    end
    load = hv && (q.size() < 2);
    acc  = m_valid && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_beat  = 0;
      m_valid = 1'b0;
    end else begin
      fin = acc && (m_beat == BEATS - 1);
      old_size = q.size();
      if (acc) beats_acc++;
      if (acc && !fin) m_beat++;
      if (fin) begin
        void'(q.pop_front());
        m_beat = 0;
        windows_done++;
      end
      if (load) q.push_back(hd);
      if (q.size() > max_cnt) max_cnt = q.size();
      if (m_valid) m_valid = !fin || (q.size() > 0);
      else         m_valid = (old_size > 0);
    end
  endtask

  task automatic drain(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while ((q.size() > 0 || m_valid) && n < max_cyc) begin
      cycle(1'b0, '0, rnd ? 1'($urandom % 2) : 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [WIN_W-1:0] wc;
    int b0, w0, n;
    bit will_load;
    rst_n = 1'b0; heu_out_ready = 1'b0; heu_data = '0; out_ready = 1'b0;

    // Reset and idle state
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(rdn_in_ready), 64'd1);

    // Single window, continuous drain
    b0 = beats_acc;
    cycle(1'b1, gen(0), 1'b1, 1'b0);
    #1 chk("lat_cnt", 64'(buf_count), 64'd1);
    chk("lat_novalid", 64'(out_valid), 64'd0);
    drain(200, 1'b0);
    chk("single_beats", 64'(beats_acc - b0), 64'(BEATS));

    // Back-to-back windows, second one three cycles after the first
    max_cnt = 0; w0 = windows_done;
    cycle(1'b1, gen(1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, gen(2), 1'b1, 1'b0);
    drain(400, 1'b0);
    chk("b2b_max_cnt", 64'(max_cnt), 64'd2);
    chk("b2b_windows", 64'(windows_done - w0), 64'd2);

    // Full with downstream stalled, third window waits for a free bank
    w0 = windows_done;
    cycle(1'b1, gen(4), 1'b0, 1'b0);
    cycle(1'b1, gen(4), 1'b0, 1'b0);
    wc = gen(4);
    for (int k = 0; k < 6; k++) cycle(1'b1, wc, 1'b0, 1'b0);
    chk("full_no_load", 64'(q.size()), 64'd2);
    n = 0; will_load = 1'b0;
    while (!will_load && n < 300) begin
      will_load = (q.size() < 2);
      cycle(1'b1, wc, 1'b1, 1'b0);
      n++;
    end
    chk("third_taken", 64'(will_load), 64'd1);
    drain(400, 1'b0);
    chk("full_windows", 64'(windows_done - w0), 64'd3);

    // Random back-pressure
    b0 = beats_acc;
    cycle(1'b1, gen(3), 1'($urandom % 2), 1'b0);
    drain(2000, 1'b1);
    chk("rand_beats", 64'(beats_acc - b0), 64'(BEATS));

    // Load on the same edge as the final beat accept
    cycle(1'b1, gen(4), 1'b1, 1'b0);
    n = 0;
    while (!(m_valid && m_beat == BEATS - 1) && n < 200) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    cycle(1'b1, gen(4), 1'b1, 1'b0);
    #1 chk("same_edge_cnt", 64'(buf_count), 64'd1);
    chk("same_edge_valid", 64'(out_valid), 64'd1);
    drain(200, 1'b0);

    // Reset mid-stream with both banks full
    cycle(1'b1, gen(4), 1'b1, 1'b0);
    cycle(1'b1, gen(4), 1'b1, 1'b0);
    n = 0;
    while (!(m_valid && m_beat == 40) && n < 200) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("mid_full", 64'(q.size()), 64'd2);
    cycle(1'b0, '0, 1'b1, 1'b1);
    #1 chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(buf_count), 64'd0);
    chk("mid_rst_ready", 64'(rdn_in_ready), 64'd1);
    b0 = beats_acc;
    cycle(1'b1, gen(4), 1'b1, 1'b0);
    drain(200, 1'b0);
    chk("post_rst_beats", 64'(beats_acc - b0), 64'(BEATS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
